// File: rtl/jtag_scan_master.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_scan_master
//  Purpose  : Clocked JTAG initiator. Turns IR/DR scan and TAP-reset commands
//             into TCK/TMS/TDI waveforms and returns the captured TDO bits.
//             Scans start from and return to Run-Test/Idle.
//  Options  : JTAG_RTI_CLOCK_EN - keep TCK running (TMS=0) while idle so the
//             TAP accumulates Run-Test/Idle clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_scan_master #(
  parameter int CLK_DIV = 2,
  parameter int IR_LEN  = 8,
  parameter int DR_MAX  = 32,
  localparam int LENW   = $clog2(DR_MAX + 1)
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_ir,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  input  logic              cmd_tlr,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (LENW > 3) ? LENW : 3;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [LENW-1:0] DR_MAX_L = LENW'(DR_MAX);
  localparam logic [LENW-1:0] IR_LEN_L = LENW'(IR_LEN);
  localparam logic [CW-1:0]   TLR_LAST = CW'(4);

  // Each non-READY state is one TCK cycle; TMS/TDI are the levels driven
  // during that cycle (SHIFT and the TLR states repeat under cnt).
  typedef enum logic [3:0] {
    INIT_TLR = 4'd0, READY = 4'd1, SEL_DR = 4'd2, SEL_IR = 4'd3,
    CAPTURE  = 4'd4, SHIFT = 4'd5, EXIT1  = 4'd6, UPDATE = 4'd7,
    IDLE_RET = 4'd8, TLR   = 4'd9
  } state_t;

  state_t            state, next_state;
  logic [CW-1:0]     cnt, next_cnt;
  logic [DR_MAX-1:0] sh, next_sh, cap;
  logic [DW-1:0]     div_cnt;
  logic [LENW-1:0]   len_r, shamt;
  logic              is_ir_r, tlr_r, start_pend, in_cmd;
  logic              active, tick, rise, fall, accept, go, finish;
  logic              tms_d, tdi_d;

  assign accept = cmd_valid & cmd_ready;
`ifdef JTAG_RTI_CLOCK_EN
  // TCK free-runs in READY; a latched command launches on a falling edge.
  assign active = 1'b1;
  assign go     = (state == READY) & start_pend & fall;
`else
  // TCK parked low in READY; a latched command launches the next clock.
  assign active = (state != READY);
  assign go     = (state == READY) & start_pend;
`endif
  assign tick   = active & (div_cnt == DIV_LAST);
  assign rise   = tick & ~tck;
  assign fall   = tick & tck;
  assign finish = (next_state == READY) & ((state != READY) | go);
  // Captured bits sit at the top of cap; this right-aligns them.
  assign shamt  = DR_MAX_L - len_r;

  // Next-state, shift data and pin levels for the upcoming TCK cycle
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_sh    = sh;
    case (state)
      INIT_TLR, TLR: if (fall) begin
        if (cnt == '0) next_state = IDLE_RET;
        else           next_cnt   = cnt - CW'(1);
      end
      IDLE_RET: if (fall) next_state = READY;
      READY: begin
        if (accept) next_sh = cmd_data;
        if (go) begin
          if (tlr_r) begin
            next_state = TLR;
            next_cnt   = TLR_LAST;
          end else if (len_r != '0) begin
            next_state = SEL_DR;
          end
        end
      end
      SEL_DR:  if (fall) next_state = is_ir_r ? SEL_IR : CAPTURE;
      SEL_IR:  if (fall) next_state = CAPTURE;
      CAPTURE: if (fall) begin
        next_state = SHIFT;
        next_cnt   = CW'(len_r) - CW'(1);
      end
      SHIFT: if (fall) begin
        next_sh = sh >> 1;
        if (cnt == '0) next_state = EXIT1;
        else           next_cnt   = cnt - CW'(1);
      end
      EXIT1:   if (fall) next_state = UPDATE;
      UPDATE:  if (fall) next_state = READY;
      default: next_state = INIT_TLR;
    endcase

    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (next_state)
      INIT_TLR, TLR, SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
      SHIFT: begin
        tms_d = (next_cnt == '0);
        tdi_d = next_sh[0];
      end
      default: ;
    endcase
  end

  // FSM state, bit counter, shift-out data and registered TMS/TDI
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= INIT_TLR;
      cnt   <= TLR_LAST;
      sh    <= '0;
      tms   <= 1'b1;
      tdi   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      sh    <= next_sh;
      tms   <= tms_d;
      tdi   <= tdi_d;
    end
  end

  // TCK divider: one toggle every CLK_DIV clocks while active
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (!active) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Command latch, TDO capture, response and handshake flags
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cap        <= '0;
      len_r      <= '0;
      is_ir_r    <= 1'b0;
      tlr_r      <= 1'b0;
      start_pend <= 1'b0;
      in_cmd     <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b1;
    end else begin
      if (rise && state == SHIFT) cap <= {tdo, cap[DR_MAX-1:1]};
      if (accept) begin
        cap        <= '0;
        is_ir_r    <= cmd_is_ir & ~cmd_tlr;
        tlr_r      <= cmd_tlr;
        if (cmd_tlr)        len_r <= '0;
        else if (cmd_is_ir) len_r <= IR_LEN_L;
        else                len_r <= (cmd_len > DR_MAX_L) ? DR_MAX_L : cmd_len;
        start_pend <= 1'b1;
        in_cmd     <= 1'b1;
        busy       <= 1'b1;
      end else if (go) begin
        start_pend <= 1'b0;
      end
      rsp_valid <= finish & in_cmd;
      if (finish) begin
        busy   <= 1'b0;
        in_cmd <= 1'b0;
        if (in_cmd) rsp_data <= cap >> shamt;
      end
      cmd_ready <= (state == READY) & ~busy & ~accept;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_scan_master
//  Purpose  : Scoreboard bench for jtag_scan_master: directed IR/DR/TLR
//             commands, TCK-edge recorder for TMS/TDI, TDO loopback model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_scan_master;

  logic        clock = 1'b0, nReset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_is_ir = 1'b0, cmd_tlr = 1'b0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [31:0] rsp_data;
  logic        tdo_one = 1'b0, lb = 1'b0;

  int          checks = 0, errors = 0, rsp_seen = 0;
  longint      t_rsp = 0, t_drive = 0;
  logic [31:0] sb_q[$];
  bit          rec_tms[$], rec_tdi[$], exp_tms[$], exp_tdi[$];

  jtag_scan_master #(.CLK_DIV(2), .IR_LEN(8), .DR_MAX(32)) dut (
    .clock(clock), .nReset(nReset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_tlr(cmd_tlr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clock = ~clock;

  // Target model: TDO is TDI delayed by one TCK cycle, or tied high
  assign tdo = tdo_one | lb;
  always @(posedge tck) lb <= tdi;

  // Recorder of TMS/TDI as seen by the TAP on each TCK rising edge
  always @(posedge tck) begin
    rec_tms.push_back(tms);
    rec_tdi.push_back(tdi);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every rsp_valid pulse pops one expected response
  initial forever begin
    @(negedge clock);
    if (rsp_valid) begin
      rsp_seen++;
      t_rsp = $time;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected rsp_valid: actual data %0h required none", rsp_data);
      end else begin
        check("rsp_data", rsp_data, sb_q.pop_front());
        check("busy at rsp", busy, 0);
      end
    end
  end

  function automatic void push_exp(input bit t, input bit d);
    exp_tms.push_back(t);
    exp_tdi.push_back(d);
  endfunction

  // Expected TMS/TDI per TCK rising edge, appended to the expectation queues
  function automatic void build(input bit ir, input bit tlr, input int len, input logic [31:0] data);
    int n;
    if (tlr) begin
      repeat (5) push_exp(1'b1, 1'b0);
      push_exp(1'b0, 1'b0);
      return;
    end
    n = ir ? 8 : ((len > 32) ? 32 : len);
    if (n == 0) return;
    push_exp(1'b1, 1'b0);
    if (ir) push_exp(1'b1, 1'b0);
    push_exp(1'b0, 1'b0);
    for (int i = 0; i < n; i++) push_exp(i == n - 1, data[i]);
    push_exp(1'b1, 1'b0);
    push_exp(1'b0, 1'b0);
  endfunction

  task automatic clear_seq();
    rec_tms.delete(); rec_tdi.delete(); exp_tms.delete(); exp_tdi.delete();
  endtask

  task automatic compare_seq(input string name);
    logic [63:0] at, ad, et, ed;
    at = '0; ad = '0; et = '0; ed = '0;
    for (int i = 0; i < rec_tms.size() && i < 64; i++) begin at[i] = rec_tms[i]; ad[i] = rec_tdi[i]; end
    for (int i = 0; i < exp_tms.size() && i < 64; i++) begin et[i] = exp_tms[i]; ed[i] = exp_tdi[i]; end
    check({name, " tck edges"}, rec_tms.size(), exp_tms.size());
    check({name, " tms"}, at, et);
    check({name, " tdi"}, ad, ed);
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!cmd_ready && k < 3000) begin @(negedge clock); k++; end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s ready timeout: actual cmd_ready 0 required 1", name);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 3000) begin @(negedge clock); k++; end
    check({name, " response"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic issue(input bit ir, input bit tlr, input int len, input logic [31:0] data,
                       input bit want, input logic [31:0] rsp, input string name);
    wait_ready(name);
    cmd_valid = 1'b1; cmd_is_ir = ir; cmd_tlr = tlr; cmd_len = len[5:0]; cmd_data = data;
    t_drive = $time;
    if (want) sb_q.push_back(rsp);
    @(negedge clock);
    cmd_valid = 1'b0;
    check({name, " accepted"}, {cmd_ready, busy}, 2'b01);
  endtask

  task automatic run(input bit ir, input bit tlr, input int len, input logic [31:0] data,
                     input logic [31:0] rsp, input string name);
    clear_seq();
    build(ir, tlr, len, data);
    issue(ir, tlr, len, data, 1'b1, rsp, name);
    wait_done(name);
    check({name, " tck parked"}, tck, 0);
    compare_seq(name);
  endtask

  initial begin
    int k;
    int seen;
    // Reset values and the initial TAP reset sequence
    repeat (3) @(negedge clock);
    check("reset pins", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, 6'b010001);
    check("reset rsp_data", rsp_data, 0);
    clear_seq();
    build(1'b0, 1'b1, 0, '0);
    nReset = 1'b1;
    wait_ready("init");
    compare_seq("init");
    check("init busy", busy, 0);
    clear_seq();
    repeat (20) @(negedge clock);
    check("idle tck edges", rec_tms.size(), 0);
    check("idle ready", {cmd_ready, tck}, 2'b10);

    run(1'b1, 1'b0, 0, 32'h32, 32'h64, "ir32");
    run(1'b0, 1'b0, 9, 32'h0CD, 32'h19A, "dr9");
    run(1'b0, 1'b0, 0, 32'hFFFF, 32'h0, "dr0");
    check("dr0 latency", t_rsp - t_drive, 20);
    tdo_one = 1'b1;
    run(1'b0, 1'b0, 32, 32'h0, 32'hFFFF_FFFF, "drmax");
    run(1'b0, 1'b0, 63, 32'h0, 32'hFFFF_FFFF, "clamp");
    tdo_one = 1'b0;
    run(1'b1, 1'b1, 5, 32'hAA, 32'h0, "tlr");

    // Back-to-back with cmd_valid held across both commands
    clear_seq();
    build(1'b1, 1'b0, 0, 32'h38);
    build(1'b0, 1'b0, 9, 32'h060);
    issue(1'b1, 1'b0, 0, 32'h38, 1'b1, 32'h70, "b2b ir");
    cmd_valid = 1'b1; cmd_is_ir = 1'b0; cmd_len = 6'd9; cmd_data = 32'h060;
    sb_q.push_back(32'h0C0);
    k = 0;
    while (!cmd_ready && k < 3000) begin @(negedge clock); k++; end
    check("b2b ready returned", cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("b2b second accept", {cmd_ready, busy}, 2'b01);
    wait_done("b2b");
    compare_seq("b2b");

    // Reset during shift bit 4 of a DR scan
    clear_seq();
    issue(1'b0, 1'b0, 9, 32'h1FF, 1'b0, 32'h0, "midscan");
    k = 0;
    while (rec_tms.size() < 7 && k < 500) begin @(negedge clock); k++; end
    check("midscan edges", rec_tms.size(), 7);
    seen = rsp_seen;
    nReset = 1'b0;
    #1;
    check("midscan reset pins", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, 6'b010001);
    clear_seq();
    build(1'b0, 1'b1, 0, '0);
    repeat (4) @(negedge clock);
    nReset = 1'b1;
    wait_ready("reinit");
    compare_seq("reinit");
    check("no rsp after reset", rsp_seen, seen);
    run(1'b1, 1'b0, 0, 32'h32, 32'h64, "ir32 again");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Clocked JTAG initiator: turns IR/DR scan commands from on-chip logic into TCK/TMS/TDI waveforms and returns the TDO bits it captures.
- It is the host end of the TAP interface exercised by our top-level JTAG tests, so we can drive the IR/DR/LED path from a soft core or bring-up FSM.
- Scans enter and leave the TAP from Run-Test/Idle (RTI).

Parameters:
- CLK_DIV, 2, system clocks per TCK half-period (>=1); TCK period = 2*CLK_DIV clocks
- IR_LEN, 8, instruction register length in bits
- DR_MAX, 32, maximum bits per scan; sets cmd_data/rsp_data width and LENW = clog2(DR_MAX+1)

Ports:
- clock  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in READY state
- cmd_is_ir  in  1  1 = IR scan (length forced to IR_LEN), 0 = DR scan
- cmd_len  in  LENW  DR bit count, 0..DR_MAX (ignored for IR)
- cmd_data  in  DR_MAX  shift-in data, LSB shifted first
- cmd_tlr  in  1  1 = TAP reset sequence instead of a scan
- rsp_valid  out  1  one-clock pulse: scan complete
- rsp_data  out  DR_MAX  captured TDO bits, right-aligned, upper bits 0
- busy  out  1  high from accept until rsp_valid
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1.
- Clock divider:
  - tck toggles every CLK_DIV clocks, only while the FSM is active; it stops low in READY.
  - tms and tdi change only at tck falling edges.
  - tdo is sampled in the clock where tck rises.
- After reset: 5 tck cycles with tms=1 (Test-Logic-Reset), then 1 cycle with tms=0, then READY with TAP in RTI; busy=0.
- Accept: cmd_valid & cmd_ready in one clock. Inputs are registered; the command is taken exactly once.
- IR scan, one tck cycle per entry:
  - TMS sequence from RTI: 1 (Select-DR), 1 (Select-IR), 0 (Capture-IR), then 0 for each shift bit with the last shift bit at 1 (Exit1), then 1 (Update), then 0 (RTI).
  - tdi = cmd_data[i] during shift bit i; tdi=0 outside Shift.
- DR scan: same sequence without the Select-IR cycle; N = cmd_len shift bits.
- Capture: rsp_data[i] = tdo sampled on the rising tck edge of shift bit i.
- FSM states: INIT_TLR, READY, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, IDLE_RET, TLR.
  - Bit counter counts N-1 down to 0; SHIFT leaves at 0.
- Completion: rsp_valid pulses the clock after the RTI tck cycle ends; rsp_data is held until the next accept.
  - busy falls with rsp_valid; cmd_ready rises the following clock.
  - Minimum one idle clock between commands.
- DR scan with cmd_len=0: accepted, no tck activity, rsp_valid next clock, rsp_data=0.
- cmd_len > DR_MAX: clamped to DR_MAX.
- cmd_tlr: 5 tck cycles tms=1, 1 cycle tms=0, rsp_valid with rsp_data=0.
- cmd_tlr has priority over cmd_is_ir when both are set.
- Reset mid-scan:
  - Outputs return to reset values immediately; any pending response is lost.
  - INIT_TLR reruns, so the TAP is resynchronised regardless of its state.
- No response backpressure: the consumer must take rsp_valid when it pulses.

Optional Feature:
- Macro: JTAG_RTI_CLOCK_EN
- Defined: in READY, tck keeps toggling at the divided rate with tms=0 and tdi=0, so the TAP accumulates Run-Test/Idle cycles (targets needing RTI clocks).
  - Accept then waits for the next tck falling edge before the scan starts.
- Undefined: tck is parked low in READY.

Test Plan:
- Reset then idle: release nReset -> 5 tck pulses with tms=1, 1 pulse tms=0, busy falls, cmd_ready=1, tck stays 0 (macro undefined).
- IR 0x32:
  - Stimulus: cmd_is_ir=1, cmd_data=0x32.
  - tms per rising edge: 1,1,0,0,0,0,0,0,0,0,1,1,0.
  - tdi over the 8 shift bits: 0,1,0,0,1,1,0,0.
  - rsp_valid one pulse.
- DR loopback:
  - Stimulus: tdo model = tdi delayed one tck cycle; cmd_len=9, cmd_data=9'b011001101.
  - tms per rising edge: 1,0,0×9 with last=1,1,0.
  - rsp_data = (data<<1) & 0x1FF with model reset state bit0 = 0, i.e. 9'b110011010.
- Edge lengths:
  - cmd_len=0 -> no tck edges, rsp_valid next clock, rsp_data=0.
  - cmd_len=DR_MAX with tdo tied 1 -> rsp_data all ones.
- Back-to-back: IR 0x38 then DR 9'b001100000 with cmd_valid held -> second accept one clock after cmd_ready returns; tdi sequences match; no extra tck edges between.
- Reset mid-shift: assert nReset at shift bit 4 of a DR scan -> tck=0, tms=1 immediately, no rsp_valid; after release, INIT_TLR sequence, then a new IR 0x32 scan is correct.
